// File: rtl/fetch_boot_unit.sv
// Instruction-fetch front end: streams BOOT_WORDS words from the BIOS into
// instruction memory, then runs the PC loop and fills the IF/ID register.
module fetch_boot_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int BOOT_WORDS   = 16,
    parameter int RESET_VECTOR = 0,
    parameter int PC_STEP      = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] boot_data,
    input  logic                  boot_valid,
    output logic                  boot_ready,
    output logic                  boot_done,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] if_id_pcpp,
    output logic [DATA_WIDTH-1:0] if_id_instruction,
    output logic                  if_id_valid
);

    // Counter must be able to hold BOOT_WORDS itself; keep at least one bit.
    localparam int CNT_W = (BOOT_WORDS > 0) ? $clog2(BOOT_WORDS + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD =
        (BOOT_WORDS > 0) ? CNT_W'(BOOT_WORDS - 1) : '0;
    localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_VECTOR);
    localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(PC_STEP);

    typedef enum logic {
        BOOT  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      boot_cnt;
    logic [ADDR_WIDTH-1:0] pc_inc;

    assign pc_inc = pc + STEP;

    // Memory pins follow the phase directly so a boot word is written in
    // the same cycle it is offered.
    assign boot_ready  = (state == BOOT);
    assign mem_cs      = 1'b0;
    assign mem_oe      = (state == FETCH);
    assign mem_we      = (state == BOOT) && boot_valid;
    assign mem_address = (state == BOOT) ? RESET_ADDR + ADDR_WIDTH'(boot_cnt) : pc;
    assign mem_wdata   = mem_we ? boot_data : '0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state             <= (BOOT_WORDS == 0) ? FETCH : BOOT;
            boot_cnt          <= '0;
            boot_done         <= 1'b0;
            pc                <= RESET_ADDR;
            if_id_pcpp        <= '0;
            if_id_instruction <= '0;
            if_id_valid       <= 1'b0;
        end else if (state == BOOT) begin
            if (boot_valid) begin
                boot_cnt <= boot_cnt + 1'b1;
                if (boot_cnt == LAST_WORD) begin
                    state     <= FETCH;
                    boot_done <= 1'b1;
                end
            end
        end else begin
            boot_done <= 1'b1;
            if (branch_taken) begin
                // The word fetched from the old PC is dropped.
                pc          <= branch_target;
                if_id_valid <= 1'b0;
            end else if (!stall) begin
                pc                <= pc_inc;
                if_id_pcpp        <= pc_inc;
                if_id_instruction <= mem_rdata;
                if_id_valid       <= !flush;
            end
        end
    end

endmodule

// File: tb/tb_fetch_boot_unit.sv
// Scoreboard bench: stimulus queues expected memory writes and IF/ID words,
// negedge monitors pop and compare whenever the DUTs present them.
module tb_fetch_boot_unit;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } pair_t;

    pair_t wr_q[$];
    pair_t ifid_q[$];
    pair_t wrap_q[$];

    int vectors = 0;
    int miscompares = 0;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    // Main DUT: 32-bit addressing, four boot words.
    logic        reset, boot_valid, boot_ready, boot_done;
    logic [31:0] boot_data, mem_address, mem_wdata, mem_rdata;
    logic        mem_cs, mem_we, mem_oe, stall, flush, branch_taken;
    logic [31:0] branch_target, pc, if_id_pcpp, if_id_instruction;
    logic        if_id_valid;

    fetch_boot_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BOOT_WORDS(4),
                      .RESET_VECTOR(0), .PC_STEP(1)) dut (
        .clock(clock), .reset(reset),
        .boot_data(boot_data), .boot_valid(boot_valid),
        .boot_ready(boot_ready), .boot_done(boot_done),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
        .mem_rdata(mem_rdata),
        .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .pc(pc), .if_id_pcpp(if_id_pcpp),
        .if_id_instruction(if_id_instruction), .if_id_valid(if_id_valid)
    );

    // Wrap DUT: 4-bit addressing, boot skipped.
    logic        w_reset, w_boot_valid, w_boot_ready, w_boot_done;
    logic [31:0] w_boot_data, w_mem_wdata, w_mem_rdata;
    logic [3:0]  w_mem_address, w_branch_target, w_pc, w_if_id_pcpp;
    logic        w_mem_cs, w_mem_we, w_mem_oe, w_stall, w_flush, w_branch_taken;
    logic [31:0] w_if_id_instruction;
    logic        w_if_id_valid;

    fetch_boot_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BOOT_WORDS(0),
                      .RESET_VECTOR(0), .PC_STEP(1)) dut_wrap (
        .clock(clock), .reset(w_reset),
        .boot_data(w_boot_data), .boot_valid(w_boot_valid),
        .boot_ready(w_boot_ready), .boot_done(w_boot_done),
        .mem_address(w_mem_address), .mem_wdata(w_mem_wdata),
        .mem_cs(w_mem_cs), .mem_we(w_mem_we), .mem_oe(w_mem_oe),
        .mem_rdata(w_mem_rdata),
        .stall(w_stall), .flush(w_flush),
        .branch_taken(w_branch_taken), .branch_target(w_branch_target),
        .pc(w_pc), .if_id_pcpp(w_if_id_pcpp),
        .if_id_instruction(w_if_id_instruction), .if_id_valid(w_if_id_valid)
    );

    logic [31:0] mem [0:255];
    logic [31:0] wmem [0:15];

    assign mem_rdata   = mem[mem_address[7:0]];
    assign w_mem_rdata = wmem[w_mem_address];

    always @(posedge clock) begin
        if (!mem_cs && mem_we) mem[mem_address[7:0]] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic boot_word(input logic [31:0] addr, input logic [31:0] data);
        boot_valid = 1'b1;
        boot_data  = data;
        wr_q.push_back('{a: addr, d: data});
        tick();
    endtask

    task automatic fetch_step(input logic [31:0] instr, input logic [31:0] pcpp);
        ifid_q.push_back('{a: pcpp, d: instr});
        tick();
    endtask

    // Monitors: compare whenever a write or a valid IF/ID word is presented.
    always @(negedge clock) begin
        pair_t e;
        if (!mem_cs && mem_we) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_write_addr", mem_address, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = wr_q.pop_front();
                chk("wr_addr", mem_address, e.a);
                chk("wr_data", mem_wdata, e.d);
            end
        end
        if (if_id_valid) begin
            if (ifid_q.size() == 0) begin
                chk("unexpected_ifid_instr", if_id_instruction, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = ifid_q.pop_front();
                chk("ifid_instr", if_id_instruction, e.d);
                chk("ifid_pcpp", if_id_pcpp, e.a);
            end
        end
        if (w_if_id_valid) begin
            if (wrap_q.size() == 0) begin
                chk("unexpected_wrap_instr", w_if_id_instruction, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = wrap_q.pop_front();
                chk("wrap_instr", w_if_id_instruction, e.d);
                chk("wrap_pcpp", w_if_id_pcpp, e.a);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 0; i < 16; i++) wmem[i] = 32'h100 + i;
        mem[8'h40] = 32'h55;
        mem[8'h41] = 32'h66;
        mem[8'h42] = 32'h77;
        wmem[15]   = 32'hCAFE;

        reset = 1'b0; boot_valid = 1'b0; boot_data = '0;
        stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = '0;
        w_reset = 1'b0; w_boot_valid = 1'b0; w_boot_data = '0;
        w_stall = 1'b0; w_flush = 1'b0; w_branch_taken = 1'b0; w_branch_target = '0;

        // Reset state
        tick(); tick();
        chk("rst_pc", pc, 0);
        chk("rst_valid", if_id_valid, 0);
        chk("rst_instr", if_id_instruction, 0);
        chk("rst_pcpp", if_id_pcpp, 0);
        chk("rst_boot_done", boot_done, 0);
        chk("rst_boot_ready", boot_ready, 1);
        chk("rst_mem_oe", mem_oe, 0);
        reset = 1'b1;

        // Boot burst
        for (int i = 0; i < 4; i++) boot_word(i, 32'hA0 + i);
        boot_valid = 1'b0;
        chk("burst_boot_done", boot_done, 1);
        chk("burst_pc", pc, 0);
        chk("burst_boot_ready", boot_ready, 0);
        chk("burst_ifid_valid", if_id_valid, 0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("reboot_boot_done", boot_done, 0);

        // Gapped boot interrupted by reset
        boot_word(0, 32'hB0);
        boot_valid = 1'b0;
        tick();
        boot_word(1, 32'hB1);
        boot_valid = 1'b0;
        chk("gap_boot_addr", mem_address, 2);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("midrst_boot_addr", mem_address, 0);
        chk("midrst_boot_done", boot_done, 0);

        // Full boot of the program used by the fetch tests
        boot_word(0, 32'h11);
        boot_word(1, 32'h22);
        boot_word(2, 32'h33);
        boot_word(3, 32'h44);
        boot_valid = 1'b0;
        chk("boot2_done", boot_done, 1);
        chk("boot2_pc", pc, 0);
        chk("fetch_mem_oe", mem_oe, 1);
        chk("fetch_mem_we", mem_we, 0);
        chk("fetch_mem_wdata", mem_wdata, 0);

        // Sequential fetch, then a two-cycle stall at pc=2
        fetch_step(32'h11, 1);
        chk("seq_pc1", pc, 1);
        fetch_step(32'h22, 2);
        chk("seq_pc2", pc, 2);
        stall = 1'b1;
        fetch_step(32'h22, 2);
        chk("stall_pc_a", pc, 2);
        fetch_step(32'h22, 2);
        chk("stall_pc_b", pc, 2);
        stall = 1'b0;
        fetch_step(32'h33, 3);
        chk("resume_pc", pc, 3);

        // Branch overrides stall
        branch_taken = 1'b1; branch_target = 32'h40; stall = 1'b1;
        tick();
        branch_taken = 1'b0; stall = 1'b0;
        chk("branch_pc", pc, 32'h40);
        chk("branch_valid", if_id_valid, 0);
        fetch_step(32'h55, 32'h41);
        chk("target_pc", pc, 32'h41);

        // Flush: loads but marks invalid, PC still advances
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_pc", pc, 32'h42);
        chk("flush_valid", if_id_valid, 0);
        chk("flush_instr", if_id_instruction, 32'h66);
        fetch_step(32'h77, 32'h43);
        chk("after_flush_pc", pc, 32'h43);
        reset = 1'b0;
        tick();

        // Wrap on the 4-bit instance
        chk("wrap_boot_ready", w_boot_ready, 0);
        w_reset = 1'b1;
        w_branch_taken = 1'b1; w_branch_target = 4'hF;
        tick();
        w_branch_taken = 1'b0;
        chk("wrap_pc_f", w_pc, 4'hF);
        chk("wrap_valid0", w_if_id_valid, 0);
        wrap_q.push_back('{a: 32'h0, d: 32'hCAFE});
        tick();
        chk("wrap_pc_0", w_pc, 4'h0);
        chk("wrap_pcpp_0", w_if_id_pcpp, 4'h0);
        w_reset = 1'b0;
        tick();
        tick();

        chk("wr_q_drained", wr_q.size(), 0);
        chk("ifid_q_drained", ifid_q.size(), 0);
        chk("wrap_q_drained", wrap_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
